fetch_unit: RTL

- IF stage plus IF/ID pipeline register.
- Drives the instruction memory request port and holds the architectural fetch PC.
- Delivers {instr, pc} to the decode stage.
- Consumes decode-side control:
  - hazard stalls (pc_write_zero, IFID_pipeline_write_zero);
  - branch/jump redirect (redirect, dest_pc).
- Supports variable-latency instruction memory, max one outstanding request, one-entry skid buffer.

---
 rtl/if_pkg.sv | 22 ++
 rtl/ifid_skid_buffer.sv | 29 ++
 rtl/fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

  // Width of the PC field carried in the IF/ID payload.
  localparam int unsigned IF_PC_W = 16;

  // addi x0,x0,0 -- the bubble that sits in IF/ID after reset or a flush.
  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]        instr;
    logic [IF_PC_W-1:0] pc;
    logic               valid;
  } ifid_t;

endpackage

// File: rtl/ifid_skid_buffer.sv
// One-entry holding slot for a fetch response that arrives while decode is
// stalled. Clear beats load, and load beats drain.
module ifid_skid_buffer
  import if_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clear,
  input  logic  load,
  input  logic  drain,
  input  ifid_t din,
  output logic  full,
  output ifid_t dout
);

  // Occupancy flag and payload.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage with IF/ID register. At most one instruction-memory request is in
// flight; a response that arrives during a decode stall parks in a one-entry
// skid buffer. Redirects flush IF/ID and squash any outstanding response.
module fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned         PC_WIDTH  = IF_PC_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = IF_NOP_INSTR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_write_zero,
  input  logic                IFID_pipeline_write_zero,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] dest_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr_D,
  output logic [PC_WIDTH-1:0] pc_D,
  output logic                valid_D
);

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc_F;
  logic [PC_WIDTH-1:0] req_pc;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] fetch_pc;
  // A response completed while pc_write_zero was high: the sequential
  // advance to req_pc+4 is deferred until the next request goes out.
  logic                pc_adv;
  logic                issue;
  logic                resp_live;
  logic                skid_load;
  logic                skid_drain;
  logic                skid_full;
  ifid_t               skid_q;
  ifid_t               resp_word;
  ifid_t               ifid_q;

  // Request issue, response qualification and skid control.
  always_comb begin
    seq_pc     = req_pc + PC_WIDTH'(4);
    fetch_pc   = pc_adv ? seq_pc : pc_F;
    issue      = !reset && (state == FETCH) && !skid_full &&
                 !pc_write_zero && !redirect;
    imem_req   = issue;
    imem_addr  = issue ? fetch_pc : '0;
    resp_live  = !reset && (state == WAIT) && imem_rvalid && !redirect;
    resp_word  = '{instr: imem_rdata, pc: IF_PC_W'(req_pc), valid: 1'b1};
    skid_load  = resp_live && IFID_pipeline_write_zero;
    skid_drain = skid_full && !IFID_pipeline_write_zero && !redirect;
  end

  // Fetch FSM and architectural PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      pc_F   <= RESET_PC;
      req_pc <= '0;
      pc_adv <= 1'b0;
    end else if (redirect) begin
      pc_F   <= dest_pc;
      pc_adv <= 1'b0;
      // An outstanding request must be soaked up before fetching dest_pc,
      // unless its response lands in this very cycle. A response consumed
      // while already in DISCARD also ends the squash.
      if (state != FETCH && !imem_rvalid) state <= DISCARD;
      else                                state <= FETCH;
    end else begin
      case (state)
        FETCH: if (issue) begin
          req_pc <= fetch_pc;
          pc_F   <= fetch_pc;
          pc_adv <= 1'b0;
          state  <= WAIT;
        end
        WAIT: if (imem_rvalid) begin
          state <= FETCH;
          if (pc_write_zero) pc_adv <= 1'b1;
          else               pc_F   <= seq_pc;
        end
        DISCARD: if (imem_rvalid) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // IF/ID register: flush, fresh response, or drain of the parked word.
  always_ff @(posedge clk) begin
    if (reset || redirect)
      ifid_q <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
    else if (resp_live && !IFID_pipeline_write_zero)
      ifid_q <= resp_word;
    else if (skid_drain)
      ifid_q <= skid_q;
  end

  ifid_skid_buffer u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .load  (skid_load),
    .drain (skid_drain),
    .din   (resp_word),
    .full  (skid_full),
    .dout  (skid_q)
  );

  assign instr_D = ifid_q.instr;
  assign pc_D    = PC_WIDTH'(ifid_q.pc);
  assign valid_D = ifid_q.valid;

endmodule
